// File: rtl/calc_pkg.sv
// Shared constants and state type for the calculator result-to-BCD converter.
package calc_pkg;

   localparam int unsigned CALC_RES_W = 16;
   localparam int unsigned CALC_NDIG  = 5;
   localparam logic [3:0]  BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } calc_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit corrector: adds 3 to any digit of 5 or more.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Pre-shift correction so that doubling carries into the next decade.
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/calc_result_bcd.sv
// Serial binary-to-BCD converter for the calculator result (double dabble,
// one bit per cycle). Optional build macro CALC_BCD_BLANK_EN replaces
// leading zero digits above the units digit with a blank code.
module calc_result_bcd
   import calc_pkg::*;
#(
   parameter int unsigned IN_W = CALC_RES_W,
   parameter int unsigned NDIG = CALC_NDIG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   RESULT_IN,
   input  logic              NEG_IN,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NDIG-1:0] BCD,
   output logic              SIGN,
   output logic              busy
);

   localparam int unsigned CW = $clog2(IN_W + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(IN_W - 1);

   calc_state_e        state_q, state_d;
   logic [IN_W-1:0]    bin_q, bin_d;
   logic [4*NDIG-1:0]  dig_q, dig_d;
   logic [4*NDIG-1:0]  dig_adj;
   logic [4*NDIG-1:0]  disp;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sign_q, sign_d;

   for (genvar i = 0; i < int'(NDIG); i++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (dig_q[4*i +: 4]),
         .dout (dig_adj[4*i +: 4])
      );
   end

   // Next-state logic: accept, one double-dabble step per SHIFT cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_d   = RESULT_IN;
               dig_d   = '0;
               cnt_d   = '0;
               sign_d  = NEG_IN && (RESULT_IN != '0);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {dig_d, bin_d} = {dig_adj, bin_q} << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset discarding any conversion in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
      end
   end

`ifdef CALC_BCD_BLANK_EN
   logic lead;

   // Blank zero digits from the top down until the first non-zero; units digit is never blanked.
   always_comb begin
      disp = dig_q;
      lead = 1'b1;
      for (int i = int'(NDIG) - 1; i >= 1; i--) begin
         if (lead && (dig_q[4*i +: 4] == 4'd0)) begin
            disp[4*i +: 4] = BLANK_CODE;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   // Raw digits including leading zeros.
   always_comb begin
      disp = dig_q;
   end
`endif

   // Handshake and output gating: nothing partial leaves the block outside DONE.
   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q != IDLE);
      out_valid = (state_q == DONE);
      BCD       = out_valid ? disp : '0;
      SIGN      = out_valid && sign_q;
   end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Self-checking bench for calc_result_bcd: directed corner cases plus randomized
// conversions compared with a decimal-arithmetic reference model.
module tb_calc_result_bcd;

   localparam int unsigned IN_W = 16;
   localparam int unsigned NDIG = 5;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   RESULT_IN;
   logic              NEG_IN;
   logic              out_valid;
   logic              out_ready;
   logic [4*NDIG-1:0] BCD;
   logic              SIGN;
   logic              busy;

   int n_checks = 0;
   int n_pass   = 0;

   calc_result_bcd #(
      .IN_W (IN_W),
      .NDIG (NDIG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .RESULT_IN (RESULT_IN),
      .NEG_IN    (NEG_IN),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .BCD       (BCD),
      .SIGN      (SIGN),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits by division, optional leading-zero blanking.
   function automatic logic [4*NDIG-1:0] ref_bcd(input int unsigned v);
      logic [4*NDIG-1:0] r;
      int unsigned       p;
      bit                seen;
      r = '0;
      p = 1;
      for (int i = 0; i < int'(NDIG); i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
`ifdef CALC_BCD_BLANK_EN
      seen = 1'b0;
      for (int i = int'(NDIG) - 1; i >= 1; i--) begin
         if (!seen && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
         else seen = 1'b1;
      end
`else
      seen = 1'b0;
`endif
      return r;
   endfunction

   // One full conversion; entered and left at a negedge with the DUT idle.
   task automatic do_conv(input int unsigned val, input logic neg, input int stall);
      int                edges;
      logic [4*NDIG-1:0] held;
      logic              ok;
      chk("idle_in_ready", in_ready, 1);
      RESULT_IN = IN_W'(val);
      NEG_IN    = neg;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      chk("shift_busy", busy, 1);
      chk("shift_in_ready", in_ready, 0);
      chk("shift_bcd_zero", BCD, 0);
      // Garbage on the inputs while converting must not matter.
      RESULT_IN = IN_W'($urandom);
      NEG_IN    = 1'($urandom);
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         RESULT_IN = IN_W'($urandom);
         NEG_IN    = 1'($urandom);
      end
      chk("latency", edges, IN_W);
      chk("bcd", BCD, ref_bcd(val));
      chk("sign", SIGN, (neg && val != 0) ? 1 : 0);
      ok = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (BCD[4*i +: 4] > 4'd9 && BCD[4*i +: 4] != 4'hF) ok = 1'b0;
      end
      chk("digit_range", ok, 1);
      held = BCD;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_bcd", BCD, held);
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_in_ready", in_ready, 1);
      chk("post_busy", busy, 0);
      chk("post_valid", out_valid, 0);
      chk("post_bcd", BCD, 0);
      chk("post_sign", SIGN, 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int   seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      RESULT_IN = '0;
      NEG_IN    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_bcd", BCD, 0);
      chk("rst_sign", SIGN, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      do_conv(65025, 1'b0, 0);
      do_conv(101, 1'b1, 0);
      do_conv(0, 1'b1, 0);
      do_conv(65535, 1'b0, 5);
      do_conv(10000, 1'b1, 1);
      do_conv(9, 1'b0, 0);

      // Reset during the 8th SHIFT cycle of a full-scale conversion.
      RESULT_IN = 16'd65535;
      NEG_IN    = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_bcd", BCD, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_partial", seen, 0);
      do_conv(440, 1'b0, 0);

      for (int k = 0; k < 25; k++) begin
         do_conv($urandom_range(0, 65535), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/calc_result_bcd.md
CALC_RESULT_BCD -- requirements
Module: calc_result_bcd

Interface
REQ-001 Parameter: IN_W, 16, magnitude width of RESULT_IN; it SHALL equal the Calculator RESULT width.
REQ-002 Parameter: NDIG, 5, number of BCD digits produced; it SHALL satisfy 10^NDIG > 2^IN_W-1.
REQ-003 Port: clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  RESULT_IN and NEG_IN hold a result to convert.
REQ-006 Port: in_ready  output  1  block can accept a result this cycle.
REQ-007 Port: RESULT_IN  input  IN_W  unsigned magnitude from Calculator RESULT.
REQ-008 Port: NEG_IN  input  1  sign flag from Calculator NEG.
REQ-009 Port: out_valid  output  1  BCD and SIGN hold a completed conversion.
REQ-010 Port: out_ready  input  1  downstream display or logger accepts the output.
REQ-011 Port: BCD  output  4*NDIG  digit codes; digit 0 (units) SHALL occupy bits [3:0].
REQ-012 Port: SIGN  output  1  minus sign for display.
REQ-013 Port: busy  output  1  high while state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on an edge where in_valid && in_ready.
REQ-016 On transfer, the block SHALL latch RESULT_IN into a shift register, clear the digit accumulator and the iteration counter, latch SIGN_q = NEG_IN && (RESULT_IN != 0), and go to SHIFT.
REQ-017 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every digit >= 5, then shift the {digits, binary} concatenation left by 1.
REQ-018 SHIFT SHALL last exactly IN_W cycles, and after the IN_W-th step the FSM SHALL enter DONE with out_valid = 1.
REQ-019 out_valid SHALL first be visible after the IN_W-th edge following the accepting edge (16 edges at default).
REQ-020 In DONE, BCD and SIGN SHALL be stable until the edge where out_valid && out_ready, after which the FSM SHALL return to IDLE.
REQ-021 The block SHALL NOT accept a new input in the same cycle as an output handshake; minimum spacing between accepts is IN_W+2 cycles.
REQ-022 in_valid SHALL be ignored outside IDLE, and RESULT_IN changes during SHIFT or DONE SHALL NOT affect the output.
REQ-023 A zero magnitude with NEG_IN=1 SHALL produce SIGN=0 (no negative zero).
REQ-024 A full-scale input of 65535 SHALL convert correctly with no overflow of digit 4.
REQ-025 BCD and SIGN SHALL be 0 whenever out_valid=0.

Reset
REQ-026 When reset=1 at an edge, the block SHALL enter IDLE and set out_valid=0, BCD=0, SIGN=0, busy=0 and in_ready=1 on the next cycle.
REQ-027 Reset in any state, including mid-SHIFT or DONE, SHALL discard the conversion in progress; no partial result SHALL ever be presented.
REQ-028 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-029 With CALC_BCD_BLANK_EN defined, the block SHALL replace every leading zero digit above digit 0 with code 4'hF (blank) in DONE, and digit 0 SHALL never be blanked.
REQ-030 Without CALC_BCD_BLANK_EN, the block SHALL present raw BCD digits, including leading zeros.
REQ-031 The macro SHALL NOT change latency, handshake behaviour or SIGN.

Structure
REQ-032 A shared package calc_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), the constants CALC_RES_W=16 and CALC_NDIG=5, and BLANK_CODE=4'hF.
REQ-033 One sub-module, bcd_add3 (a combinational 4-bit digit corrector), SHALL be instantiated NDIG times, and all sequencing SHALL stay in calc_result_bcd.

Verification
REQ-034 RESULT_IN=65025, NEG_IN=0, out_ready=1 -> out_valid rises 16 edges after accept; BCD=6_5_0_2_5, SIGN=0.
REQ-035 RESULT_IN=101, NEG_IN=1 -> SIGN=1; BCD=0_0_1_0_1 without the macro, F_F_1_0_1 with it.
REQ-036 RESULT_IN=0, NEG_IN=1 -> SIGN=0; BCD=0_0_0_0_0, or F_F_F_F_0 with CALC_BCD_BLANK_EN.
REQ-037 out_ready held low 5 cycles in DONE with in_valid=1 throughout -> BCD stable, in_ready=0, nothing accepted; IDLE and in_ready=1 the cycle after out_ready=1.
REQ-038 reset pulsed on the 8th SHIFT cycle of 65535 -> next cycle IDLE, out_valid=0; a following 440 converts to 0_0_4_4_0 in 16 edges.
REQ-039 RESULT_IN=65535 -> BCD=6_5_5_3_5, with a check that no digit ever exceeds 9.
